// File: rtl/apb_strobe_fifo_if.sv
// Bus bundle between the APB IO block, the strobe FIFO and the DSP core.
// The slave side is the FIFO; the master side drives writes and the consumer ready.
interface apb_strobe_fifo_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] wr_data;
    logic             wr_strobe;
    logic             status_clear;
    logic [31:0]      status;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output wr_data, wr_strobe, status_clear, out_ready,
        input  status, out_data, out_valid
    );

    modport slave (
        input  wr_data, wr_strobe, status_clear, out_ready,
        output status, out_data, out_valid
    );
endinterface

// File: rtl/apb_strobe_fifo.sv
// Edge-triggered write FIFO between an APB IO strobe and a streaming consumer.
// First-word-fall-through with a registered head word and a registered status word.
module apb_strobe_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic               clock_clk,
    input  logic               reset,
    apb_strobe_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             strobe_d_reg;
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0]    level_reg, level_next;
    logic             ovf_reg, ovf_next;
    logic             out_valid_reg, out_valid_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic [31:0]      status_reg, status_next;

    logic push_req, pop, full, push_acc, ovf_event;

    always_comb begin
        push_req  = bus.wr_strobe & ~strobe_d_reg;
        pop       = out_valid_reg & bus.out_ready;
        full      = (level_reg == FULL_LEVEL);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_acc  = push_req & (~full | pop);
        ovf_event = push_req & full & ~pop;

        wr_ptr_next = push_acc ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
        rd_ptr_next = pop      ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

        level_next = level_reg;
        if (push_acc && !pop)
            level_next = level_reg + LW'(1);
        else if (pop && !push_acc)
            level_next = level_reg - LW'(1);

        ovf_next       = ovf_event | (ovf_reg & ~bus.status_clear);
        out_valid_next = (level_next != '0);

        // The only word not yet in memory is the one written this cycle; it is
        // the new head exactly when it ends up alone in the FIFO.
        if (push_acc && level_next == LW'(1))
            out_data_next = bus.wr_data;
        else if (level_next != '0)
            out_data_next = mem[rd_ptr_next];
        else
            out_data_next = out_data_reg;

        status_next = {ovf_next, (level_next == '0), (level_next == FULL_LEVEL),
                       20'd0, 9'(level_next)};
    end

    always_ff @(posedge clock_clk) begin
        if (push_acc)
            mem[wr_ptr_reg] <= bus.wr_data;
    end

    always_ff @(posedge clock_clk or posedge reset) begin
        if (reset) begin
            // Strobe history starts high so a strobe held across reset is not a write.
            strobe_d_reg  <= 1'b1;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            status_reg    <= 32'h4000_0000;
        end else begin
            strobe_d_reg  <= bus.wr_strobe;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            level_reg     <= level_next;
            ovf_reg       <= ovf_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            status_reg    <= status_next;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.status    = status_reg;
endmodule
